// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command frame parser driving a register write port
//
// Consumes bytes from uartrx over a 4-phase req/ack handshake, parses
// SYNC/ADDR/DATA/CHK frames and issues one register write per valid frame.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   rx_data   received byte, valid while rx_req=1
//   rx_req    byte-available request from uartrx
//   rx_ack    acknowledge to uartrx
//   wr_addr   write address
//   wr_data   write data
//   wr_en     write valid
//   wr_ready  register bank accepts write
//   frame_ok  one-cycle pulse after a write is accepted
//   err_cnt   saturating checksum/timeout error count
//   busy      high in any state other than IDLE
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_req,
  output logic       rx_ack,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  input  logic       wr_ready,
  output logic       frame_ok,
  output logic [7:0] err_cnt,
  output logic       busy
);

  // Counter only ever reaches TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int              CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_WRITE
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] tmo_cnt;
  logic [CW-1:0] tmo_cnt_d;

  logic          rx_ack_d;
  logic [7:0]    wr_addr_d;
  logic [7:0]    wr_data_d;
  logic          wr_en_d;
  logic          frame_ok_d;
  logic [7:0]    err_cnt_d;
  logic          busy_d;

  logic capture;
  logic in_frame;
  logic tmo_hit;
  logic chk_ok;
  logic accept;
  logic err_inc;

  // A new byte is taken only on the leading edge of req; WRITE holds off
  // the receiver by never raising ack.
  assign capture  = rx_req && !rx_ack && (state != S_WRITE);
  assign in_frame = (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
  // A capture in the final cycle rescues the frame.
  assign tmo_hit  = in_frame && !capture && (tmo_cnt == TMO_LAST);
  assign chk_ok   = (rx_data == (wr_addr ^ wr_data));
  assign accept   = wr_en && wr_ready;
  assign err_inc  = ((state == S_CHK) && capture && !chk_ok) || tmo_hit;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tmo_cnt  <= '0;
      rx_ack   <= 1'b0;
      wr_addr  <= 8'h00;
      wr_data  <= 8'h00;
      wr_en    <= 1'b0;
      frame_ok <= 1'b0;
      err_cnt  <= 8'h00;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      tmo_cnt  <= tmo_cnt_d;
      rx_ack   <= rx_ack_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      wr_en    <= wr_en_d;
      frame_ok <= frame_ok_d;
      err_cnt  <= err_cnt_d;
      busy     <= busy_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (capture && (rx_data == SYNC)) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (capture)      state_d = S_DATA;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_DATA: begin
        if (capture)      state_d = S_CHK;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_CHK: begin
        if (capture)      state_d = chk_ok ? S_WRITE : S_IDLE;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_WRITE: begin
        if (accept) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    rx_ack_d   = rx_ack;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    err_cnt_d  = err_cnt;
    tmo_cnt_d  = '0;

    if (capture)     rx_ack_d = 1'b1;
    else if (!rx_req) rx_ack_d = 1'b0;

    if ((state == S_ADDR) && capture) wr_addr_d = rx_data;
    if ((state == S_DATA) && capture) wr_data_d = rx_data;

    if (err_inc && (err_cnt != 8'hFF)) err_cnt_d = err_cnt + 8'd1;

    // Clearing on capture also covers entry to ADDR.
    if (in_frame && !capture && !tmo_hit) tmo_cnt_d = tmo_cnt + 1'b1;

    wr_en_d    = (state_d == S_WRITE);
    frame_ok_d = accept;
    busy_d     = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - directed self-checking bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_req = 1'b0;
  logic       rx_ack;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       wr_ready = 1'b1;
  logic       frame_ok;
  logic [7:0] err_cnt;
  logic       busy;

  int tests  = 0;
  int failed = 0;

  // Bus monitor
  int         wr_cnt    = 0;
  int         fo_cnt    = 0;
  int         fo_bad    = 0;
  int         ack_rise  = 0;
  logic [7:0] last_addr = 8'h00;
  logic [7:0] last_data = 8'h00;
  logic       acc_q     = 1'b0;
  logic       ack_q     = 1'b0;

  uart_cmd_ctrl #(.SYNC(8'hA5), .TIMEOUT(4000)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_req   (rx_req),
    .rx_ack   (rx_ack),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .wr_ready (wr_ready),
    .frame_ok (frame_ok),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en && wr_ready) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
    end
    acc_q <= wr_en && wr_ready;
    if (frame_ok) fo_cnt <= fo_cnt + 1;
    if (frame_ok !== acc_q) fo_bad <= fo_bad + 1;
    ack_q <= rx_ack;
    if (rx_ack && !ack_q) ack_rise <= ack_rise + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    rx_data = b;
    rx_req  = 1'b1;
    n = 0;
    while (!rx_ack && n < 50) begin @(negedge clk); n++; end
    check("ack_rise", {31'd0, rx_ack}, 32'd1);
    rx_req = 1'b0;
    n = 0;
    while (rx_ack && n < 50) begin @(negedge clk); n++; end
    check("ack_fall", {31'd0, rx_ack}, 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d);
    send_byte(c);
  endtask

  initial begin
    int  w0, a0, f0, n;
    logic acked;

    // Reset state
    #1;
    check("rst_rx_ack",   {31'd0, rx_ack},   32'd0);
    check("rst_wr_en",    {31'd0, wr_en},    32'd0);
    check("rst_wr_addr",  {24'd0, wr_addr},  32'd0);
    check("rst_wr_data",  {24'd0, wr_data},  32'd0);
    check("rst_frame_ok", {31'd0, frame_ok}, 32'd0);
    check("rst_err_cnt",  {24'd0, err_cnt},  32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    cycles(3);
    rst = 1'b0;
    cycles(2);

    // Normal frame
    w0 = wr_cnt; a0 = ack_rise; f0 = fo_cnt;
    send_frame(8'h10, 8'h3C, 8'h2C);
    cycles(4);
    check("norm_writes",  wr_cnt - w0,      32'd1);
    check("norm_addr",    {24'd0, last_addr}, 32'h10);
    check("norm_data",    {24'd0, last_data}, 32'h3C);
    check("norm_fo",      fo_cnt - f0,      32'd1);
    check("norm_acks",    ack_rise - a0,    32'd4);
    check("norm_err",     {24'd0, err_cnt}, 32'd0);
    check("norm_busy",    {31'd0, busy},    32'd0);

    // Garbage before sync
    w0 = wr_cnt; a0 = ack_rise;
    send_byte(8'h55);
    check("garb_busy55", {31'd0, busy}, 32'd0);
    send_byte(8'h12);
    send_frame(8'h20, 8'h01, 8'h21);
    cycles(4);
    check("garb_acks",   ack_rise - a0,      32'd6);
    check("garb_writes", wr_cnt - w0,        32'd1);
    check("garb_addr",   {24'd0, last_addr}, 32'h20);
    check("garb_data",   {24'd0, last_data}, 32'h01);
    check("garb_err",    {24'd0, err_cnt},   32'd0);

    // Bad checksum, then a good frame
    w0 = wr_cnt;
    send_frame(8'h10, 8'h3C, 8'h2D);
    cycles(4);
    check("bad_writes", wr_cnt - w0,      32'd0);
    check("bad_err",    {24'd0, err_cnt}, 32'd1);
    check("bad_busy",   {31'd0, busy},    32'd0);
    send_frame(8'h01, 8'h02, 8'h03);
    cycles(4);
    check("good_writes", wr_cnt - w0,        32'd1);
    check("good_addr",   {24'd0, last_addr}, 32'h01);
    check("good_data",   {24'd0, last_data}, 32'h02);

    // Inter-byte timeout
    send_byte(8'hA5);
    send_byte(8'h10);
    cycles(3900);
    check("tmo_busy_pre", {31'd0, busy},    32'd1);
    check("tmo_err_pre",  {24'd0, err_cnt}, 32'd1);
    cycles(200);
    check("tmo_busy",     {31'd0, busy},    32'd0);
    check("tmo_err",      {24'd0, err_cnt}, 32'd2);
    w0 = wr_cnt;
    send_frame(8'h07, 8'h08, 8'h0F);
    cycles(4);
    check("tmo_next_writes", wr_cnt - w0,        32'd1);
    check("tmo_next_addr",   {24'd0, last_addr}, 32'h07);
    check("tmo_next_data",   {24'd0, last_data}, 32'h08);

    // Backpressure while the next frame's SYNC waits
    wr_ready = 1'b0;
    w0 = wr_cnt;
    send_frame(8'h33, 8'h44, 8'h77);
    check("bp_wr_en",   {31'd0, wr_en},   32'd1);
    check("bp_busy",    {31'd0, busy},    32'd1);
    rx_data = 8'hA5;
    rx_req  = 1'b1;
    acked   = 1'b0;
    repeat (3000) begin
      @(negedge clk);
      if (rx_ack) acked = 1'b1;
    end
    check("bp_no_ack",   {31'd0, acked},   32'd0);
    check("bp_wr_hold",  {31'd0, wr_en},   32'd1);
    check("bp_addr",     {24'd0, wr_addr}, 32'h33);
    check("bp_data",     {24'd0, wr_data}, 32'h44);
    check("bp_writes0",  wr_cnt - w0,      32'd0);
    wr_ready = 1'b1;
    n = 0;
    while (!rx_ack && n < 50) begin @(negedge clk); n++; end
    check("bp_ack_after", {31'd0, rx_ack},   32'd1);
    check("bp_writes1",   wr_cnt - w0,        32'd1);
    check("bp_wr_addr",   {24'd0, last_addr}, 32'h33);
    check("bp_wr_data",   {24'd0, last_data}, 32'h44);
    check("bp_busy_sync", {31'd0, busy},      32'd1);
    rx_req = 1'b0;
    n = 0;
    while (rx_ack && n < 50) begin @(negedge clk); n++; end
    check("bp_ack_fall", {31'd0, rx_ack}, 32'd0);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h33);
    cycles(4);
    check("bp2_writes", wr_cnt - w0,        32'd2);
    check("bp2_addr",   {24'd0, last_addr}, 32'h55);
    check("bp2_data",   {24'd0, last_data}, 32'h66);
    check("fo_pairing", fo_bad,             32'd0);

    // Reset mid-frame, seen without any clock edge
    send_byte(8'hA5);
    send_byte(8'h10);
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_busy",    {31'd0, busy},    32'd0);
    check("mid_err",     {24'd0, err_cnt}, 32'd0);
    check("mid_wr_addr", {24'd0, wr_addr}, 32'd0);
    cycles(2);
    rst = 1'b0;
    w0 = wr_cnt;
    send_frame(8'h0A, 8'h0B, 8'h01);
    cycles(4);
    check("mid_writes", wr_cnt - w0,        32'd1);
    check("mid_addr",   {24'd0, last_addr}, 32'h0A);
    check("mid_data",   {24'd0, last_data}, 32'h0B);

    // Error count saturation
    for (int i = 0; i < 254; i++) send_frame(8'h00, 8'h00, 8'h01);
    cycles(2);
    check("sat_254", {24'd0, err_cnt}, 32'hFE);
    send_frame(8'h00, 8'h00, 8'h01);
    cycles(2);
    check("sat_255", {24'd0, err_cnt}, 32'hFF);
    for (int i = 0; i < 5; i++) send_frame(8'h00, 8'h00, 8'h01);
    cycles(2);
    check("sat_260", {24'd0, err_cnt}, 32'hFF);
    check("sat_busy", {31'd0, busy},   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
